// File: rtl/gate_tester_pkg.sv
// Shared definitions for the gate tester: FSM state encoding, truth-table
// constants for common two-input gates, and the per-vector compare helper.
package gate_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Expected C for each vector, indexed by {B,A}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Index of the final vector in the 00,10,01,11 sequence
    localparam logic [1:0] LAST_IDX = 2'd3;

    // True when the observed response disagrees with the truth table entry
    function automatic logic vec_mismatch(input logic [3:0] truth,
                                          input logic [1:0] vec,
                                          input logic       c);
        return (truth[vec] != c);
    endfunction

endpackage

// File: rtl/gate_tester_settle_timer.sv
// Settle counter for the gate tester. Counts cycles a vector has been held;
// expire marks the cycle in which the gate response is sampled.
module settle_timer #(
    parameter int SETTLE = 10,
    parameter int W      = $clog2(SETTLE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expire
);

    logic [W-1:0] cnt_r;

    // Counter register: cleared on reset or load, advances on tick
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == W'(SETTLE - 1));

endmodule

// File: rtl/gate_tester.sv
// Exhaustive two-input gate tester. Walks the four input vectors
// (A,B) = 00,10,01,11, holds each for SETTLE cycles, compares the gate
// response C against TRUTH and reports per-vector failures and a count.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int         SETTLE = 10,
    parameter logic [3:0] TRUTH  = TT_AND
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    state_t     state_r, state_s;
    logic [1:0] idx_r, idx_s;
    logic       a_r, a_s;
    logic       b_r, b_s;
    logic [2:0] err_r, err_s;
    logic [3:0] fail_r, fail_s;
    logic       busy_r, done_r, pass_r;
    logic       load_s, tick_s, expire_s;
    logic [1:0] vec_s;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .tick   (tick_s),
        .expire (expire_s)
    );

    // Next-state and datapath update: start arms a run, each expire samples C
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        a_s     = a_r;
        b_s     = b_r;
        err_s   = err_r;
        fail_s  = fail_r;
        load_s  = 1'b0;
        tick_s  = 1'b0;
        vec_s   = {b_r, a_r};
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_SETTLE;
                    idx_s   = 2'd0;
                    a_s     = 1'b0;
                    b_s     = 1'b0;
                    err_s   = 3'd0;
                    fail_s  = 4'd0;
                    load_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (expire_s) begin
                    if (vec_mismatch(TRUTH, vec_s, C)) begin
                        fail_s[vec_s] = 1'b1;
                        err_s         = err_r + 3'd1;
                    end else begin
                        err_s = err_r;
                    end
                    load_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                        a_s     = 1'b0;
                        b_s     = 1'b0;
                    end else begin
                        idx_s = idx_r + 2'd1;
                        a_s   = idx_s[0];
                        b_s   = idx_s[1];
                    end
                end else begin
                    tick_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = 2'd0;
                a_s     = 1'b0;
                b_s     = 1'b0;
                err_s   = 3'd0;
                fail_s  = 4'd0;
                load_s  = 1'b1;
            end
        endcase
    end

    // State and output registers; status flags are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            err_r   <= 3'd0;
            fail_r  <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            a_r     <= a_s;
            b_r     <= b_s;
            err_r   <= err_s;
            fail_r  <= fail_s;
            busy_r  <= (state_s == ST_SETTLE);
            done_r  <= (state_s == ST_DONE);
            pass_r  <= (state_s == ST_DONE) && (err_s == 3'd0);
        end
    end

    assign A         = a_r;
    assign B         = b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_vec  = fail_r;

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: four instances cover an AND gate at
// SETTLE=10 and SETTLE=1, a stuck-high response, and a wrong truth table.
module tb_gate_tester;
    import gate_tester_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic a_and, b_and, busy_and, done_and, pass_and;
    logic [2:0] err_and;
    logic [3:0] fail_and;
    logic a_c1, b_c1, busy_c1, done_c1, pass_c1;
    logic [2:0] err_c1;
    logic [3:0] fail_c1;
    logic a_s1, b_s1, busy_s1, done_s1, pass_s1;
    logic [2:0] err_s1;
    logic [3:0] fail_s1;
    logic a_xor, b_xor, busy_xor, done_xor, pass_xor;
    logic [2:0] err_xor;
    logic [3:0] fail_xor;

    always #5 clk = ~clk;

    gate_tester #(.SETTLE(10), .TRUTH(TT_AND)) u_and (
        .clk(clk), .rst(rst), .start(start), .A(a_and), .B(b_and), .C(a_and & b_and),
        .busy(busy_and), .done(done_and), .pass(pass_and), .err_count(err_and), .fail_vec(fail_and));
    gate_tester #(.SETTLE(10), .TRUTH(TT_AND)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .A(a_c1), .B(b_c1), .C(1'b1),
        .busy(busy_c1), .done(done_c1), .pass(pass_c1), .err_count(err_c1), .fail_vec(fail_c1));
    gate_tester #(.SETTLE(1), .TRUTH(TT_AND)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .A(a_s1), .B(b_s1), .C(a_s1 & b_s1),
        .busy(busy_s1), .done(done_s1), .pass(pass_s1), .err_count(err_s1), .fail_vec(fail_s1));
    gate_tester #(.SETTLE(10), .TRUTH(TT_XOR)) u_xor (
        .clk(clk), .rst(rst), .start(start), .A(a_xor), .B(b_xor), .C(a_xor & b_xor),
        .busy(busy_xor), .done(done_xor), .pass(pass_xor), .err_count(err_xor), .fail_vec(fail_xor));

    // advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        step(); step();
        n_cmp++; if ({a_and, b_and} !== 2'b00) begin n_bad++; $display("FAIL reset_ab got %b want 00", {a_and, b_and}); end
        n_cmp++; if ({busy_and, done_and, pass_and} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy_and, done_and, pass_and}); end
        n_cmp++; if (err_and !== 3'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err_and); end
        n_cmp++; if (fail_and !== 4'b0000) begin n_bad++; $display("FAIL reset_fail got %b want 0000", fail_and); end
        rst = 1'b0;
        step();
        n_cmp++; if ({busy_c1, done_c1} !== 2'b00) begin n_bad++; $display("FAIL idle_flags got %b want 00", {busy_c1, done_c1}); end
    endtask

    // full run from a single start pulse; traces A/B and latency cycle by cycle
    task automatic test_vectors();
        int v;
        logic exp_a, exp_b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) step();
            v = t / 10;
            exp_a = (t < 40) ? v[0] : 1'b0;
            exp_b = (t < 40) ? v[1] : 1'b0;
            n_cmp++; if ({a_and, b_and} !== {exp_a, exp_b}) begin n_bad++; $display("FAIL and_ab t=%0d got %b want %b", t, {a_and, b_and}, {exp_a, exp_b}); end
            n_cmp++; if (busy_and !== (t < 40)) begin n_bad++; $display("FAIL and_busy t=%0d got %b want %b", t, busy_and, (t < 40)); end
            n_cmp++; if (done_and !== (t >= 40)) begin n_bad++; $display("FAIL and_done t=%0d got %b want %b", t, done_and, (t >= 40)); end
            exp_a = (t < 4) ? t[0] : 1'b0;
            exp_b = (t < 4) ? t[1] : 1'b0;
            n_cmp++; if ({a_s1, b_s1} !== {exp_a, exp_b}) begin n_bad++; $display("FAIL s1_ab t=%0d got %b want %b", t, {a_s1, b_s1}, {exp_a, exp_b}); end
            n_cmp++; if (done_s1 !== (t >= 4)) begin n_bad++; $display("FAIL s1_done t=%0d got %b want %b", t, done_s1, (t >= 4)); end
            n_cmp++; if (pass_s1 !== (t >= 4)) begin n_bad++; $display("FAIL s1_pass t=%0d got %b want %b", t, pass_s1, (t >= 4)); end
            n_cmp++; if (pass_and !== (t >= 40)) begin n_bad++; $display("FAIL and_pass t=%0d got %b want %b", t, pass_and, (t >= 40)); end
        end
        n_cmp++; if ({err_and, fail_and} !== {3'd0, 4'b0000}) begin n_bad++; $display("FAIL and_result got %0d/%b want 0/0000", err_and, fail_and); end
        n_cmp++; if ({done_c1, pass_c1, err_c1, fail_c1} !== {1'b1, 1'b0, 3'd3, 4'b0111}) begin n_bad++; $display("FAIL c1_result got d%b p%b %0d/%b want d1 p0 3/0111", done_c1, pass_c1, err_c1, fail_c1); end
        n_cmp++; if ({done_xor, pass_xor, err_xor, fail_xor} !== {1'b1, 1'b0, 3'd3, 4'b1110}) begin n_bad++; $display("FAIL xor_result got d%b p%b %0d/%b want d1 p0 3/1110", done_xor, pass_xor, err_xor, fail_xor); end
        n_cmp++; if ({err_s1, fail_s1} !== {3'd0, 4'b0000}) begin n_bad++; $display("FAIL s1_result got %0d/%b want 0/0000", err_s1, fail_s1); end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if ({done_and, pass_and} !== 2'b11) begin n_bad++; $display("FAIL and_hold got %b want 11", {done_and, pass_and}); end
        n_cmp++; if ({done_xor, err_xor, fail_xor} !== {1'b1, 3'd3, 4'b1110}) begin n_bad++; $display("FAIL xor_hold got %b/%0d/%b want 1/3/1110", done_xor, err_xor, fail_xor); end
    endtask

    // reset in the middle of a run discards partial results; start under rst is ignored
    task automatic test_rst_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if ({busy_c1, err_c1, fail_c1} !== {1'b1, 3'd1, 4'b0001}) begin n_bad++; $display("FAIL mid_partial got %b/%0d/%b want 1/1/0001", busy_c1, err_c1, fail_c1); end
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        n_cmp++; if ({busy_c1, done_c1, pass_c1, a_c1, b_c1} !== 5'b00000) begin n_bad++; $display("FAIL mid_rst_flags got %b want 00000", {busy_c1, done_c1, pass_c1, a_c1, b_c1}); end
        n_cmp++; if ({err_c1, fail_c1} !== {3'd0, 4'b0000}) begin n_bad++; $display("FAIL mid_rst_result got %0d/%b want 0/0000", err_c1, fail_c1); end
        n_cmp++; if ({busy_and, done_and, pass_and} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_and got %b want 000", {busy_and, done_and, pass_and}); end
        step();
        n_cmp++; if (busy_and !== 1'b0) begin n_bad++; $display("FAIL mid_idle got %b want 0", busy_and); end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) step();
        n_cmp++; if ({done_and, pass_and, err_and} !== {1'b1, 1'b1, 3'd0}) begin n_bad++; $display("FAIL mid_rerun_and got %b%b/%0d want 11/0", done_and, pass_and, err_and); end
        n_cmp++; if ({done_c1, err_c1, fail_c1} !== {1'b1, 3'd3, 4'b0111}) begin n_bad++; $display("FAIL mid_rerun_c1 got %b/%0d/%b want 1/3/0111", done_c1, err_c1, fail_c1); end
    endtask

    // start held through a run changes nothing; a later start in DONE clears results
    task automatic test_back_to_back();
        int v;
        start = 1'b1;
        step();
        for (int t = 1; t <= 40; t++) begin
            step();
            v = t / 10;
            if (t < 40) begin
                n_cmp++; if ({busy_c1, a_c1, b_c1} !== {1'b1, v[0], v[1]}) begin n_bad++; $display("FAIL held_trace t=%0d got %b want %b", t, {busy_c1, a_c1, b_c1}, {1'b1, v[0], v[1]}); end
            end else begin
                start = 1'b0;
            end
        end
        n_cmp++; if ({done_c1, err_c1, fail_c1} !== {1'b1, 3'd3, 4'b0111}) begin n_bad++; $display("FAIL held_c1 got %b/%0d/%b want 1/3/0111", done_c1, err_c1, fail_c1); end
        n_cmp++; if ({done_and, pass_and} !== 2'b11) begin n_bad++; $display("FAIL held_and got %b want 11", {done_and, pass_and}); end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if ({busy_c1, done_c1, pass_c1} !== 3'b100) begin n_bad++; $display("FAIL restart_flags got %b want 100", {busy_c1, done_c1, pass_c1}); end
        n_cmp++; if ({err_c1, fail_c1} !== {3'd0, 4'b0000}) begin n_bad++; $display("FAIL restart_clear got %0d/%b want 0/0000", err_c1, fail_c1); end
        for (int i = 0; i < 40; i++) step();
        n_cmp++; if ({done_c1, err_c1, fail_c1} !== {1'b1, 3'd3, 4'b0111}) begin n_bad++; $display("FAIL restart_c1 got %b/%0d/%b want 1/3/0111", done_c1, err_c1, fail_c1); end
        n_cmp++; if ({done_xor, err_xor, fail_xor} !== {1'b1, 3'd3, 4'b1110}) begin n_bad++; $display("FAIL restart_xor got %b/%0d/%b want 1/3/1110", done_xor, err_xor, fail_xor); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 Parameter SETTLE, default 10, is the number of clk cycles each input vector is held before C is sampled; legal range is 1..255.
REQ-002 Parameter TRUTH, default 4'b1000 (AND), holds the expected C for each vector; the bit index is {B,A}.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to run a test; sampled only in IDLE or DONE.
REQ-006 A  output  1  registered stimulus to the gate under test.
REQ-007 B  output  1  registered stimulus to the gate under test.
REQ-008 C  input  1  response from the gate under test.
REQ-009 busy  output  1  high while a test is running (SETTLE state).
REQ-010 done  output  1  high while results are valid (DONE state).
REQ-011 pass  output  1  high in DONE when err_count==0; otherwise low.
REQ-012 err_count  output  3  number of mismatching vectors, 0..4.
REQ-013 fail_vec  output  4  bit {B,A} is set when that vector mismatched.

Function
REQ-014 The FSM SHALL have three states: IDLE, SETTLE and DONE.
REQ-015 IDLE or DONE with start=1: at that edge, idx:=0, A:=0, B:=0, cnt:=0, err_count:=0 and fail_vec:=0; the FSM then goes to SETTLE.
REQ-016 Vector order SHALL be idx 0..3 with A=idx[0] and B=idx[1], giving (A,B) = 00, 10, 01, 11.
REQ-017 In SETTLE, cnt SHALL increment each cycle; at the edge where cnt==SETTLE-1, C is sampled and compared with TRUTH[{B,A}].
REQ-018 On a mismatch at the sample edge, fail_vec[{B,A}]:=1 and err_count:=err_count+1, both on that same edge.
REQ-019 At a sample edge with idx<3: idx increments, A and B take the new vector, cnt:=0, and the FSM stays in SETTLE.
REQ-020 At a sample edge with idx==3: the FSM goes to DONE and A:=0, B:=0.
REQ-021 Latency: with start accepted at edge k, done first reads high after edge k+4*SETTLE.
REQ-022 In DONE, done, pass, err_count and fail_vec SHALL hold until the next start or rst.
REQ-023 start while in SETTLE SHALL be ignored, with no effect on the vector sequence.
REQ-024 pass and done SHALL be low in every state other than DONE.
REQ-025 With SETTLE==1, each vector lasts exactly one cycle and C is sampled at the edge after A and B change.
REQ-026 err_count SHALL never exceed 4; no wrap-around logic is needed.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, A=0, B=0, idx=0, cnt=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-028 rst asserted mid-test SHALL abort the test with no partial results retained; start is ignored in any cycle where rst=1.

Structure
REQ-029 A shared package SHALL hold the state encoding and the truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110 and TT_NAND=4'b0111.
REQ-030 A sub-module settle_timer (load, tick, expire; width $clog2(SETTLE+1)) SHALL implement cnt.
REQ-031 The gate under test SHALL be instantiated outside gate_tester and connected only through A, B and C.

Verification
REQ-032 gate_tester driving andGate, SETTLE=10, pulse start: after 40 cycles, done=1, pass=1, err_count=0, fail_vec=4'b0000.
REQ-033 TRUTH=TT_AND with C tied to 1: done=1, pass=0, err_count=3, fail_vec=4'b0111.
REQ-034 SETTLE=1 driving andGate: A,B trace 00,10,01,11 on consecutive cycles; done after 4 cycles; pass=1.
REQ-035 rst asserted 15 cycles into a test: next cycle shows IDLE, all outputs 0; a new start then completes normally.
REQ-036 start held high throughout a test: the sequence is unchanged; a second start in DONE restarts with err_count cleared.
REQ-037 TRUTH=TT_XOR driving andGate: fail_vec=4'b1110, err_count=3, pass=0.
